prio_encoder_hs: RTL
====================

# prio_encoder_hs

Parametrised, handshaked priority encoder that turns an N-bit request vector into a sequence of binary indices, one per set bit. It is the successor to the fixed 4-to-2 one-hot encoder: it accepts any number of set bits, with N configurable, instead of flagging them invalid. It sits between request-collection logic (interrupt lines, dirty-line masks, grant vectors) and a consumer that services one index at a time under valid/ready flow control.

## Interface
- `N`, default 8: request vector width; legal range 2..256.
- `W`, derived localparam: $clog2(N), the index width; not overridable.
- `clk` input, 1 bit: rising-edge clock.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `in_vec` input, N bits: request vector; bit i requests index i.
- `in_valid` input, 1 bit: `in_vec` is valid.
- `in_ready` output, 1 bit: block can capture a vector this cycle.
- `out_idx` output, W bits: index of the currently presented set bit.
- `out_valid` output, 1 bit: `out_idx` is valid.
- `out_ready` input, 1 bit: consumer accepts `out_idx`.
- `out_last` output, 1 bit: `out_idx` is the final set bit of the captured vector.

## Operation
- State is a `pend` register of N bits plus a 2-state FSM.
  - IDLE: `pend` is 0.
  - DRAIN: `pend` is nonzero.
- Capture: when `in_valid` and `in_ready` are both high at a clock edge, `pend` loads `in_vec`.
  - If `in_vec` is nonzero, the FSM goes to DRAIN.
  - If `in_vec` is 0, the vector is accepted and discarded. No output is produced and the FSM stays in IDLE.
- Selection: `out_idx` is the position of the lowest set bit of `pend` (LSB-first priority; see Configuration).
- `out_valid` = (state == DRAIN).
- `out_last` = DRAIN and exactly one bit of `pend` is set.
- Pop: when `out_valid` and `out_ready` are both high at an edge, the bit at `out_idx` is cleared in `pend`. If that bit was the last one, the FSM returns to IDLE.
- `in_ready` = IDLE, or (`out_valid` and `out_ready` and `out_last`). This allows a new vector to be captured in the same cycle as the final pop, with no bubble.
- Simultaneous final pop and capture: `pend` takes the new `in_vec`. The FSM goes to DRAIN, or to IDLE if `in_vec` is 0.
- Changes on `in_vec` while in DRAIN are ignored; the captured vector is never modified by the input.
- Under backpressure (`out_valid` high, `out_ready` low), `out_idx` and `out_last` stay stable until the pop.
- Reset, asynchronous at any time, including mid-drain:
  - `pend` = 0 and the FSM goes to IDLE.
  - `out_valid` = 0, `out_idx` = 0, `out_last` = 0.
  - `in_ready` is forced to 0 while `rst_n` is low and returns to 1 in the first cycle after release.
  - Any partially drained vector is lost.

## Timing
- Capture at edge T; the first index is valid after edge T (cycle T+1).
- Throughput is one index per cycle while `out_ready` is held high.
- A vector with k set bits occupies exactly k output cycles when there is no backpressure.
- `out_idx`, `out_valid` and `out_last` are derived only from registered state, with no combinational path from `in_*`.
- `in_ready` has a combinational path from `out_ready`. This is the only input-to-output path.
- Priority selection is a log-depth tree over N bits and must close timing at N=64 within one cycle.

## Configuration
- `PRIO_ENC_MSB_FIRST_EN`:
  - Defined: selection picks the highest set bit of `pend`, so indices are emitted in descending order. `out_last` is unchanged in meaning.
  - Undefined (default): LSB-first selection, ascending order.
  - All handshake and timing behaviour is identical in both builds.

## Test plan
All scenarios use N=8.
- **Reset values:** assert `rst_n`=0 mid-operation, then release → `out_valid`=0, `out_idx`=0, `out_last`=0, and `in_ready`=1 one cycle after release.
- **Basic drain:** `in_vec`=8'b1010_0100 with `out_ready` held at 1 → `out_idx` is 2, 5, 7 on three consecutive cycles, `out_last`=1 only with 7, then `in_ready`=1.
- **Backpressure and ignored input:** same vector, with `out_ready`=0 for 3 cycles after the first index → `out_idx` holds at 2 with `out_valid`=1, and `in_vec` changes during the stall have no effect.
- **Back-to-back and zero vector:**
  - 8'b0000_0001 followed immediately by 8'b1000_0000 → `out_idx` is 0 then 7 with no idle cycle, and `out_last`=1 on both.
  - `in_vec`=0 → accepted, `out_valid` stays 0.
- **Reset mid-drain:** reset asserted after the first pop of 8'hFF → outputs clear immediately, and the next vector 8'b0001_0000 yields only `out_idx`=4.
- **MSB-first build:** with `PRIO_ENC_MSB_FIRST_EN` defined, 8'b1010_0100 → `out_idx` is 7, 5, 2, with `out_last` on 2.

Source files
------------

// File: rtl/prio_encoder_hs.sv
// Handshaked priority encoder: emits the index of every set bit of a captured vector, one per pop.
// Define PRIO_ENC_MSB_FIRST_EN to emit indices highest-first instead of lowest-first.
`timescale 1ns/1ps

module prio_encoder_hs #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in_vec,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_idx,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last
);

    localparam int P = 1 << W;

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [N-1:0] pend;
    logic [N-1:0] pend_nxt;
    logic [W-1:0] sel_idx;
    logic         pop;
    logic         cap;
    logic         pop_last;

    logic [P-1:0] padded;
    logic [W-1:0] tidx [W+1][P];
    logic         tval [W+1][P];

    // Binary selection tree: each level merges sibling pairs, so depth is W levels of 2:1 muxing.
    always_comb begin
        padded = '0;
        padded[N-1:0] = pend;
        for (int l = 0; l <= W; l++) begin
            for (int j = 0; j < P; j++) begin
                tidx[l][j] = '0;
                tval[l][j] = 1'b0;
            end
        end
        for (int j = 0; j < P; j++) begin
            tval[0][j] = padded[j];
        end
        for (int l = 1; l <= W; l++) begin
            for (int j = 0; j < (P >> l); j++) begin
                tval[l][j] = tval[l-1][2*j] | tval[l-1][2*j+1];
`ifdef PRIO_ENC_MSB_FIRST_EN
                if (tval[l-1][2*j+1]) begin
                    tidx[l][j]        = tidx[l-1][2*j+1];
                    tidx[l][j][l-1]   = 1'b1;
                end else begin
                    tidx[l][j]        = tidx[l-1][2*j];
                end
`else
                if (tval[l-1][2*j]) begin
                    tidx[l][j]        = tidx[l-1][2*j];
                end else begin
                    tidx[l][j]        = tidx[l-1][2*j+1];
                    tidx[l][j][l-1]   = 1'b1;
                end
`endif
            end
        end
        sel_idx = tidx[W][0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pend  <= '0;
        end else begin
            state <= state_nxt;
            pend  <= pend_nxt;
        end
    end

    // Outputs come only from registered state; in_ready alone looks through to out_ready.
    always_comb begin
        out_valid = (state == DRAIN);
        out_idx   = out_valid ? sel_idx : '0;
        out_last  = out_valid && ((pend & (pend - N'(1))) == '0);
        pop       = out_valid && out_ready;
        pop_last  = pop && out_last;
        in_ready  = rst_n && ((state == IDLE) || pop_last);
        cap       = in_valid && in_ready;

        pend_nxt  = pend;
        state_nxt = state;
        if (pop) begin
            pend_nxt = pend & ~(N'(1) << sel_idx);
        end
        if (cap) begin
            pend_nxt = in_vec;
        end

        case (state)
            IDLE: begin
                if (cap && (in_vec != '0)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pop_last) begin
                    state_nxt = (cap && (in_vec != '0)) ? DRAIN : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
